// File: rtl/alu_iter.sv
// Iterative integer ALU: add/sub/logic/compare/shift in one cycle, mul/mulhu/div/rem by 1-bit-per-cycle iteration.
// Latency: 1 cycle for single-cycle ops and divide-by-zero, XLEN+1 cycles for iterative ops.
// Backpressure: one request in flight; in_ready only in IDLE, result held in DONE until out_ready.
module alu_iter #(
   parameter int XLEN = 64,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            nrst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] res,
   output logic            eq
);

   localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4,  OP_SLT  = 4'd5,  OP_SLTU = 4'd6,  OP_SLL  = 4'd7;
   localparam logic [3:0] OP_SRL  = 4'd8,  OP_SRA  = 4'd9,  OP_MUL  = 4'd10, OP_MULHU = 4'd11;
   localparam logic [3:0] OP_DIV  = 4'd12, OP_DIVU = 4'd13, OP_REM  = 4'd14, OP_REMU = 4'd15;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t              state, state_nxt;
   logic [3:0]          op_q;
   logic [XLEN-1:0]     dvs_q;
   logic [2*XLEN-1:0]   acc_q, acc_nxt;
   logic [SHW-1:0]      cnt_q;
   logic                qneg_q, rneg_q;
   logic [XLEN-1:0]     res_q;
   logic                eq_q;

   logic                accept, last_iter, is_iter, is_mul, div_signed;
   logic                a_neg, b_neg;
   logic [XLEN-1:0]     a_mag, b_mag, sc_res, fin_res;
   logic [XLEN:0]       mul_sum, rem_sh, diff;

   assign res = res_q;
   assign eq  = eq_q;

   always_comb begin
      is_mul     = (op == OP_MUL) || (op == OP_MULHU);
      div_signed = (op == OP_DIV) || (op == OP_REM);
      // divide by zero is resolved immediately, never iterated
      is_iter    = is_mul || ((op >= OP_DIV) && (rs2 != '0));
      a_neg      = div_signed && rs1[XLEN-1];
      b_neg      = div_signed && rs2[XLEN-1];
      a_mag      = a_neg ? -rs1 : rs1;
      b_mag      = b_neg ? -rs2 : rs2;
      accept     = (state == IDLE) && in_valid;
      last_iter  = (state == BUSY) && (cnt_q == SHW'(XLEN-1));
   end

   always_comb begin
      sc_res = '0;
      case (op)
         OP_ADD:  sc_res = rs1 + rs2;
         OP_SUB:  sc_res = rs1 - rs2;
         OP_AND:  sc_res = rs1 & rs2;
         OP_OR:   sc_res = rs1 | rs2;
         OP_XOR:  sc_res = rs1 ^ rs2;
         OP_SLT:  sc_res = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
         OP_SLTU: sc_res = {{(XLEN-1){1'b0}}, (rs1 < rs2)};
         OP_SLL:  sc_res = rs1 << rs2[SHW-1:0];
         OP_SRL:  sc_res = rs1 >> rs2[SHW-1:0];
         OP_SRA:  sc_res = XLEN'($signed(rs1) >>> rs2[SHW-1:0]);
         OP_DIV, OP_DIVU: sc_res = '1;
         OP_REM, OP_REMU: sc_res = rs1;
         default: sc_res = '0;
      endcase
   end

   // acc holds {partial product high, multiplier} for mul and {remainder, quotient} for div
   always_comb begin
      mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
      rem_sh  = acc_q[2*XLEN-1:XLEN-1];
      diff    = rem_sh - {1'b0, dvs_q};
      acc_nxt = acc_q;
      if ((op_q == OP_MUL) || (op_q == OP_MULHU))
         acc_nxt = {mul_sum, acc_q[XLEN-1:1]};
      else if (!diff[XLEN])
         acc_nxt = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else
         acc_nxt = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
   end

   always_comb begin
      fin_res = '0;
      case (op_q)
         OP_MUL:   fin_res = acc_nxt[XLEN-1:0];
         OP_MULHU: fin_res = acc_nxt[2*XLEN-1:XLEN];
         OP_DIV:   fin_res = qneg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
         OP_DIVU:  fin_res = acc_nxt[XLEN-1:0];
         OP_REM:   fin_res = rneg_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
         OP_REMU:  fin_res = acc_nxt[2*XLEN-1:XLEN];
         default:  fin_res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = is_iter ? BUSY : DONE;
         end
         BUSY: if (last_iter) state_nxt = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         op_q   <= '0;
         dvs_q  <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
         res_q  <= '0;
         eq_q   <= 1'b0;
      end else if (accept) begin
         op_q   <= op;
         eq_q   <= (rs1 == rs2);
         cnt_q  <= '0;
         qneg_q <= a_neg ^ b_neg;
         rneg_q <= a_neg;
         acc_q  <= {{XLEN{1'b0}}, (is_mul ? rs1 : a_mag)};
         dvs_q  <= is_mul ? rs2 : b_mag;
         if (!is_iter) res_q <= sc_res;
      end else if (state == BUSY) begin
         acc_q <= acc_nxt;
         cnt_q <= cnt_q + SHW'(1);
         if (last_iter) res_q <= fin_res;
      end
   end

endmodule
